// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN engine: default width, opcodes and FSM states.
package rpn_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_OP,
    POP_B,
    WAIT_B,
    POP_A,
    WAIT_A,
    PUSH_R
  } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN engine; results wrap modulo 2^W.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_res
);

  always_comb begin
    o_res = i_b;
    case (i_op)
      OP_ADD:  o_res = i_a + i_b;
      OP_SUB:  o_res = i_a - i_b;
      OP_MUL:  o_res = i_a * i_b;
      default: o_res = i_b;
    endcase
  end

endmodule

// File: rtl/rpn_engine.sv
// RPN token sequencer driving an external stack through a push/pop handshake.
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [W-1:0] tok_data,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         err,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [W-1:0] stk_din,
  input  logic [W-1:0] stk_dout,
  input  logic         stk_full,
  input  logic         stk_empty
);

  state_t       r_state;
  logic [1:0]   r_op;
  logic [W-1:0] r_operand;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_res_data;
  logic         r_err;

  logic [W-1:0] w_alu_res;
  logic         w_in_push_r;
  logic         w_out_now;

  rpn_alu #(.W(W)) u_alu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_res (w_alu_res)
  );

  // Stack strobes are decoded from the registered state so the stack sees
  // them in the state cycle itself; stk_dout is only valid during WAIT_*.
  assign w_in_push_r = (r_state == PUSH_R);
  assign w_out_now   = (r_state == WAIT_B) && (r_op == OP_OUT);

  assign tok_ready = (r_state == IDLE);
  assign stk_push  = ((r_state == PUSH_OP) && !stk_full) || w_in_push_r;
  assign stk_pop   = ((r_state == POP_B) || (r_state == POP_A)) && !stk_empty;
  assign stk_din   = w_in_push_r ? w_alu_res : r_operand;
  assign res_valid = w_in_push_r || w_out_now;
  assign res_data  = w_in_push_r ? w_alu_res : (w_out_now ? stk_dout : r_res_data);
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= OP_ADD;
      r_operand  <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tok_valid) begin
            if (tok_is_op) begin
              r_op    <= tok_data[1:0];
              r_state <= POP_B;
            end else begin
              r_operand <= tok_data;
              r_state   <= PUSH_OP;
            end
          end
        end
        PUSH_OP: begin
          if (stk_full) r_err <= 1'b1;
          r_state <= IDLE;
        end
        POP_B: begin
          if (stk_empty) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          r_b <= stk_dout;
          if (r_op == OP_OUT) begin
            r_res_data <= stk_dout;
            r_state    <= IDLE;
          end else begin
            r_state <= POP_A;
          end
        end
        POP_A: begin
          // A missing A operand drops the already-popped B on the floor.
          if (stk_empty) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= WAIT_A;
          end
        end
        WAIT_A: begin
          r_a     <= stk_dout;
          r_state <= PUSH_R;
        end
        PUSH_R: begin
          r_res_data <= w_alu_res;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_engine.sv
// Self-checking bench for rpn_engine: behavioural depth-3 stack plus a queue-based RPN model.
module tb_rpn_engine;

  localparam int W     = 16;
  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_is_op = 1'b0;
  logic [W-1:0] tok_data = '0;
  logic         tok_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         err;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_din;
  logic [W-1:0] stk_dout;
  logic         stk_full;
  logic         stk_empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rpn_engine #(.W(W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
  );

  // External stack: popped word appears on stk_dout the cycle after the pop.
  logic [W-1:0] s_mem [0:DEPTH-1];
  int           s_cnt;
  assign stk_full  = (s_cnt == DEPTH);
  assign stk_empty = (s_cnt == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt    <= 0;
      stk_dout <= '0;
    end else if (stk_push && s_cnt < DEPTH) begin
      s_mem[s_cnt] <= stk_din;
      s_cnt        <= s_cnt + 1;
    end else if (stk_pop && s_cnt > 0) begin
      stk_dout <= s_mem[s_cnt-1];
      s_cnt    <= s_cnt - 1;
    end
  end

  int           n_push = 0;
  int           n_pop = 0;
  int           n_overlap = 0;
  logic [W-1:0] obs_res [$];

  always @(negedge clk) begin
    if (stk_push) n_push++;
    if (stk_pop) n_pop++;
    if (stk_push && stk_pop) n_overlap++;
    if (res_valid) obs_res.push_back(res_data);
  end

  logic [W-1:0] m_stk [$];
  bit           m_err;
  logic [W-1:0] m_last;

  function automatic logic [W-1:0] apply_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] wide;
    case (op)
      2'b00:   wide = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      2'b01:   wide = {{W{1'b0}}, a} - {{W{1'b0}}, b};
      default: wide = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endcase
    return wide[W-1:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tok_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_stk.delete();
    m_err  = 1'b0;
    m_last = '0;
    @(negedge clk);
  endtask

  task automatic do_token(input bit is_op, input logic [W-1:0] data, input string tag);
    int           exp_lat, exp_push, exp_pop, lat, wc, p0, q0, r0;
    bit           exp_res;
    logic [W-1:0] exp_val, a, b;
    exp_res = 1'b0; exp_val = '0; exp_push = 0; exp_pop = 0; exp_lat = 2;
    if (!is_op) begin
      if (m_stk.size() >= DEPTH) m_err = 1'b1;
      else begin m_stk.push_back(data); exp_push = 1; end
    end else if (m_stk.size() == 0) begin
      m_err = 1'b1;
    end else begin
      b = m_stk.pop_back();
      exp_pop = 1;
      if (data[1:0] == 2'b11) begin
        exp_lat = 3; exp_res = 1'b1; exp_val = b;
      end else if (m_stk.size() == 0) begin
        exp_lat = 4; m_err = 1'b1;
      end else begin
        a = m_stk.pop_back();
        exp_pop = 2; exp_push = 1; exp_res = 1'b1; exp_lat = 6;
        exp_val = apply_op(data[1:0], a, b);
        m_stk.push_back(exp_val);
      end
    end
    if (exp_res) m_last = exp_val;

    wc = 0;
    while (!tok_ready && wc < 20) begin @(negedge clk); wc++; end
    checks++;
    if (tok_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_wait: tok_ready=%b expected 1", tag, tok_ready);
    end
    p0 = n_push; q0 = n_pop; r0 = obs_res.size();
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = data;
    @(negedge clk);
    tok_valid = 1'b0; tok_data = W'($urandom);
    lat = 1;
    while (!tok_ready && lat < 20) begin @(negedge clk); lat++; end
    #1;
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    checks++;
    if (n_push - p0 != exp_push) begin
      errors++; $display("FAIL %s pushes: got %0d expected %0d", tag, n_push - p0, exp_push);
    end
    checks++;
    if (n_pop - q0 != exp_pop) begin
      errors++; $display("FAIL %s pops: got %0d expected %0d", tag, n_pop - q0, exp_pop);
    end
    checks++;
    if (obs_res.size() - r0 != int'(exp_res)) begin
      errors++;
      $display("FAIL %s res_pulses: got %0d expected %0d", tag, obs_res.size() - r0, exp_res);
    end else if (exp_res) begin
      checks++;
      if (obs_res[r0] !== exp_val) begin
        errors++; $display("FAIL %s res_value: got %h expected %h", tag, obs_res[r0], exp_val);
      end
    end
    checks++;
    if (res_data !== m_last) begin
      errors++; $display("FAIL %s res_hold: got %h expected %h", tag, res_data, m_last);
    end
    checks++;
    if (err !== m_err) begin
      errors++; $display("FAIL %s err: got %b expected %b", tag, err, m_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, err, stk_push, stk_pop, tok_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: got valid/err/push/pop/ready=%b expected 00001",
               {res_valid, err, stk_push, stk_pop, tok_ready});
    end
    checks++;
    if (res_data !== '0 || stk_din !== '0) begin
      errors++; $display("FAIL reset_data: res_data=%h stk_din=%h expected 0", res_data, stk_din);
    end
    do_reset();
    checks++;
    if (tok_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", tok_ready);
    end
  endtask

  task automatic test_add();
    int p0, q0;
    do_reset();
    p0 = n_push; q0 = n_pop;
    do_token(1'b0, 16'd3, "add_a");
    do_token(1'b0, 16'd4, "add_b");
    do_token(1'b1, 16'h0000, "add_op");
    checks++;
    if (n_push - p0 != 3 || n_pop - q0 != 2 || res_data !== 16'd7 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_summary: pushes=%0d pops=%0d res=%h err=%b expected 3 2 0007 0",
               n_push - p0, n_pop - q0, res_data, err);
    end
  endtask

  task automatic test_sub();
    do_reset();
    do_token(1'b0, 16'd5, "sub_a");
    do_token(1'b0, 16'd9, "sub_b");
    do_token(1'b1, 16'h0001, "sub_op");
    checks++;
    if (res_data !== 16'hFFFC) begin
      errors++; $display("FAIL sub_wrap: got %h expected fffc", res_data);
    end
  endtask

  task automatic test_mul_out();
    int p0;
    do_reset();
    do_token(1'b0, 16'h0100, "mul_a");
    do_token(1'b0, 16'h0100, "mul_b");
    do_token(1'b1, 16'h0002, "mul_op");
    checks++;
    if (res_data !== 16'h0000) begin
      errors++; $display("FAIL mul_wrap: got %h expected 0000", res_data);
    end
    p0 = n_push;
    do_token(1'b1, 16'h0003, "mul_out");
    checks++;
    if (n_push != p0 || s_cnt != 0) begin
      errors++; $display("FAIL out_nopush: pushes=%0d depth=%0d expected 0 0", n_push - p0, s_cnt);
    end
  endtask

  task automatic test_underflow();
    int q0;
    do_reset();
    q0 = n_pop;
    do_token(1'b1, 16'h0000, "uf_add");
    checks++;
    if (err !== 1'b1 || n_pop != q0) begin
      errors++; $display("FAIL uf_flag: err=%b pops=%0d expected 1 0", err, n_pop - q0);
    end
    do_token(1'b0, 16'd42, "uf_sticky_push");
    do_token(1'b1, 16'h0000, "uf_at_a");
  endtask

  task automatic test_full();
    int p0;
    do_reset();
    do_token(1'b0, 16'd10, "full_1");
    do_token(1'b0, 16'd20, "full_2");
    do_token(1'b0, 16'd30, "full_3");
    p0 = n_push;
    do_token(1'b0, 16'd1, "full_ovf");
    checks++;
    if (err !== 1'b1 || n_push != p0) begin
      errors++; $display("FAIL full_flag: err=%b pushes=%0d expected 1 0", err, n_push - p0);
    end
    do_token(1'b1, 16'h0003, "full_out");
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    do_token(1'b0, 16'd3, "mid_a");
    do_token(1'b0, 16'd4, "mid_b");
    do_token(1'b1, 16'h0000, "mid_add");
    do_token(1'b0, 16'd11, "mid_c");
    do_token(1'b0, 16'd22, "mid_d");
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 16'h0000;
    @(negedge clk);
    tok_valid = 1'b0;
    repeat (3) @(negedge clk);
    p0 = n_push;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res_valid, stk_push, stk_pop, tok_ready} !== 4'b0001 || res_data !== '0 ||
        stk_din !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: valid/push/pop/ready=%b res=%h din=%h err=%b expected 0001 0 0 0",
               {res_valid, stk_push, stk_pop, tok_ready}, res_data, stk_din, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_stk.delete(); m_err = 1'b0; m_last = '0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (n_push != p0 || tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: pushes=%0d ready=%b expected 0 1", n_push - p0, tok_ready);
    end
    do_token(1'b0, 16'd77, "mid_resume");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) do_token(1'b1, W'($urandom), "rnd_op");
      else do_token(1'b0, W'($urandom), "rnd_val");
    end
    checks++;
    if (s_cnt != m_stk.size()) begin
      errors++; $display("FAIL rnd_depth: got %0d expected %0d", s_cnt, m_stk.size());
    end else begin
      for (int k = 0; k < s_cnt; k++) begin
        checks++;
        if (s_mem[k] !== m_stk[k]) begin
          errors++; $display("FAIL rnd_stack[%0d]: got %h expected %h", k, s_mem[k], m_stk[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_out();
    test_underflow();
    test_full();
    test_reset_mid();
    test_random();
    checks++;
    if (n_overlap != 0) begin
      errors++; $display("FAIL push_pop_overlap: got %0d cycles expected 0", n_overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpn_engine.md
RPN_ENGINE -- requirements
Module: rpn_engine

Interface
REQ-001 SHALL have parameter W, default 16: data width of tokens, stack words and results.
REQ-002 SHALL have port clk  in  1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port tok_valid  in  1: token present.
REQ-005 SHALL have port tok_ready  out  1: engine can accept a token.
REQ-006 SHALL have port tok_is_op  in  1: 1 = operator, 0 = operand.
REQ-007 SHALL have port tok_data  in  W: operand value, or opcode in bits [1:0].
REQ-008 SHALL have port res_valid  out  1: one-cycle result pulse.
REQ-009 SHALL have port res_data  out  W: result value, held until the next pulse.
REQ-010 SHALL have port err  out  1: sticky overflow/underflow flag.
REQ-011 SHALL have port stk_push  out  1: push request to the external stack.
REQ-012 SHALL have port stk_pop  out  1: pop request to the external stack.
REQ-013 SHALL have port stk_din  out  W: word to push.
REQ-014 SHALL have port stk_dout  in  W: popped word, valid the cycle after stk_pop.
REQ-015 SHALL have ports stk_full and stk_empty  in  1 each: stack status, reflecting the post-edge state.

Function
REQ-016 SHALL accept a token on a rising edge with tok_valid && tok_ready.
REQ-017 SHALL drive tok_ready=1 only in state IDLE.
REQ-018 SHALL never assert stk_push and stk_pop in the same cycle.
REQ-019 SHALL handle an operand token as follows: IDLE -> PUSH_OP; in PUSH_OP, if !stk_full, assert stk_push for one cycle with stk_din=operand; if stk_full, set err and push nothing; then return to IDLE.
REQ-020 SHALL decode opcodes as 00 ADD (A+B), 01 SUB (A-B), 10 MUL (low W bits of A*B), 11 OUT (pop the top of stack to res_data and push nothing back).
REQ-021 SHALL take B as the top of stack and A as the next entry down.
REQ-022 SHALL compute all arithmetic modulo 2^W with no saturation and no carry output.
REQ-023 SHALL sequence a binary operator through IDLE -> POP_B -> WAIT_B -> POP_A -> WAIT_A -> PUSH_R -> IDLE.
REQ-024 SHALL, in POP_B and POP_A, assert stk_pop for one cycle if !stk_empty.
REQ-025 SHALL capture stk_dout into the B register in WAIT_B and into the A register in WAIT_A.
REQ-026 SHALL, in PUSH_R, push the ALU result and pulse res_valid with res_data=result in the same cycle.
REQ-027 SHALL sequence OUT as IDLE -> POP_B -> WAIT_B -> IDLE, pulsing res_valid with res_data=B in WAIT_B.
REQ-028 SHALL treat stk_empty in POP_B or POP_A as underflow: set err, issue no pop, return to IDLE, and produce no result. An operand already popped as B stays discarded.
REQ-029 SHALL keep err set until reset and continue accepting tokens while err=1.
REQ-030 SHALL have latencies of 2 cycles per operand token, 6 cycles per binary operator token (accept edge to IDLE), and 3 cycles per OUT token.

Reset
REQ-031 SHALL, on reset low, immediately return the FSM to IDLE and clear res_valid, res_data, err, stk_push, stk_pop, stk_din and the A/B registers to 0.
REQ-032 SHALL drive tok_ready=1 after reset release.
REQ-033 SHALL abort any sequence in progress when reset asserts mid-operation, with no further push or pop issued. Stack contents are the stack's own concern.

Structure
REQ-034 SHALL place the opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_OUT), the FSM state encoding and the default W in shared package rpn_pkg.
REQ-035 SHALL place the combinational ALU (A, B, opcode -> result) in sub-module rpn_alu.
REQ-036 SHALL leave the stack storage outside rpn_engine; the two connect only through the stk_* ports.

Verification
REQ-037 SHALL cover: operands 3, 4, op ADD -> two pushes, two pops, push 7, res_valid with res_data=7, err=0.
REQ-038 SHALL cover: operands 5, 9, op SUB (W=16) -> res_data=0xFFFC (5-9 mod 2^16).
REQ-039 SHALL cover: operands 0x0100, 0x0100, op MUL -> res_data=0x0000, then OUT -> res_valid with res_data=0x0000 and no push.
REQ-040 SHALL cover: empty stack, op ADD -> err=1, no stk_pop, no res_valid, tok_ready high again in cycle 2.
REQ-041 SHALL cover: with the stack depth-3 full, operand 1 -> err=1, no stk_push issued.
REQ-042 SHALL cover: reset asserted in WAIT_A -> outputs 0 immediately, FSM in IDLE, tok_ready=1 after release, no push of a result.
